// File: rtl/spi_controller.sv
// SPI mode-0 initiator: serialises one 16-bit frame {rw, addr[6:0], data[7:0]}
// MSB first on copi, with sclk idling low and ncs framing the transfer.
// Frame sequence: IDLE -> SHIFT (16 bits) -> HOLD (ncs low) -> GAP (ncs high) -> IDLE.
module spi_controller #(
   parameter int CLK_DIV = 4   // clk cycles per sclk half-period, legal 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_rw,
   input  logic [6:0] req_addr,
   input  logic [7:0] req_data,
   output logic       sclk,
   output logic       copi,
   output logic       ncs,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2,
      GAP   = 2'd3
   } state_t;

   localparam logic [7:0] HALF_MAX = 8'(CLK_DIV - 1);

   state_t      state;
   logic [15:0] shift;     // frame latched at accept; shifted left on each sclk fall
   logic [7:0]  hcnt;      // clk cycles elapsed within the current half-period
   logic [3:0]  bit_cnt;   // bits completed; the fall that ends bit 15 ends SHIFT
   logic        half_done;

   // The controller can accept a new frame only while idle.
   assign req_ready = (state == IDLE);
   assign half_done = (hcnt == HALF_MAX);

   // Frame sequencer: every output except req_ready is a register updated here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift   <= '0;
         hcnt    <= '0;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         copi    <= 1'b0;
         ncs     <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch reads the
         // pre-edge values of sclk/shift/bit_cnt regardless of statement order.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  shift   <= {req_rw, req_addr, req_data};
                  copi    <= req_rw;
                  ncs     <= 1'b0;
                  busy    <= 1'b1;
                  sclk    <= 1'b0;
                  hcnt    <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               if (half_done) begin
                  hcnt <= '0;
                  sclk <= ~sclk;
                  // Falling edge: advance to the next bit, or stop after bit 15
                  // leaving copi on the last bit.
                  if (sclk) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == 4'd15) begin
                        state <= HOLD;
                     end else begin
                        shift <= {shift[14:0], 1'b0};
                        copi  <= shift[14];
                     end
                  end
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            HOLD: begin
               if (half_done) begin
                  hcnt  <= '0;
                  ncs   <= 1'b1;
                  sclk  <= 1'b0;
                  copi  <= 1'b0;
                  state <= GAP;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            GAP: begin
               if (half_done) begin
                  hcnt  <= '0;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  hcnt <= hcnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: one instance with CLK_DIV=4, one with
// CLK_DIV=1, sharing clock, reset and request fields; req_valid is steered to
// the instance selected by sel1 and its outputs are observed through a mux.
module tb_spi_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sel1 = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_rw = 1'b0;
   logic [6:0] req_addr = '0;
   logic [7:0] req_data = '0;

   logic v4, ready4, sclk4, copi4, ncs4, busy4, done4;
   logic v1, ready1, sclk1, copi1, ncs1, busy1, done1;
   logic obs_ready, obs_sclk, obs_copi, obs_ncs, obs_busy, obs_done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] stream;
      int rises;
      int ncs_low;
      int ncs_high_tail;
      int done_at;
      int done_cnt;
      int busy_cnt;
      int glitch;
   } frame_res_t;

   always #5 clk = ~clk;

   assign v4 = req_valid & ~sel1;
   assign v1 = req_valid & sel1;
   assign obs_ready = sel1 ? ready1 : ready4;
   assign obs_sclk  = sel1 ? sclk1  : sclk4;
   assign obs_copi  = sel1 ? copi1  : copi4;
   assign obs_ncs   = sel1 ? ncs1   : ncs4;
   assign obs_busy  = sel1 ? busy1  : busy4;
   assign obs_done  = sel1 ? done1  : done4;

   spi_controller #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(ready4),
      .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
      .sclk(sclk4), .copi(copi4), .ncs(ncs4), .busy(busy4), .done(done4)
   );

   spi_controller #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
      .req_rw(req_rw), .req_addr(req_addr), .req_data(req_data),
      .sclk(sclk1), .copi(copi1), .ncs(ncs1), .busy(busy1), .done(done1)
   );

   // Present a request and return exactly at the accepting clock edge.
   task automatic start_frame(input logic rw, input logic [6:0] a, input logic [7:0] d,
                              output bit ok);
      ok = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_rw    = rw;
      req_addr  = a;
      req_data  = d;
      for (int n = 0; n < 400; n++) begin
         if (obs_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   // Called at the accept edge E0; observes samples #1 after E0..E(34d).
   task automatic capture(input int d, output frame_res_t r);
      logic ps, pc;
      r = '{stream: '0, rises: 0, ncs_low: 0, ncs_high_tail: 0, done_at: -1,
            done_cnt: 0, busy_cnt: 0, glitch: 0};
      ps = 1'b0;
      pc = 1'b0;
      for (int j = 0; j <= 34 * d; j++) begin
         if (j > 0) @(posedge clk);
         #1;
         if (j == 0) begin
            if (!(obs_ncs === 1'b0 && obs_busy === 1'b1 && obs_sclk === 1'b0)) r.glitch++;
         end else begin
            if (obs_sclk === 1'b1 && ps === 1'b0) begin
               if (j != d + 2 * d * r.rises) r.glitch++;
               r.stream = {r.stream[14:0], obs_copi};
               r.rises++;
            end
            if (j < 33 * d && obs_copi !== pc && !(ps === 1'b1 && obs_sclk === 1'b0)) r.glitch++;
         end
         if (obs_ncs === 1'b0) r.ncs_low++;
         else if (j > 0) r.ncs_high_tail++;
         if (obs_busy === 1'b1) r.busy_cnt++;
         if (obs_done === 1'b1) begin
            r.done_cnt++;
            if (r.done_at < 0) r.done_at = j;
         end
         ps = obs_sclk;
         pc = obs_copi;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ready4 !== 1'b1) begin failures++; $display("FAIL rst_ready4 got=%b want=1", ready4); end
      checks++; if (ncs4 !== 1'b1)   begin failures++; $display("FAIL rst_ncs4 got=%b want=1", ncs4); end
      checks++; if (sclk4 !== 1'b0)  begin failures++; $display("FAIL rst_sclk4 got=%b want=0", sclk4); end
      checks++; if (copi4 !== 1'b0)  begin failures++; $display("FAIL rst_copi4 got=%b want=0", copi4); end
      checks++; if (busy4 !== 1'b0)  begin failures++; $display("FAIL rst_busy4 got=%b want=0", busy4); end
      checks++; if (done4 !== 1'b0)  begin failures++; $display("FAIL rst_done4 got=%b want=0", done4); end
      checks++; if (ready1 !== 1'b1 || ncs1 !== 1'b1 || busy1 !== 1'b0) begin
         failures++; $display("FAIL rst_dut1 ready=%b ncs=%b busy=%b want 1/1/0", ready1, ncs1, busy1);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (ready4 !== 1'b1 || ncs4 !== 1'b1 || busy4 !== 1'b0) begin
         failures++; $display("FAIL post_rst ready=%b ncs=%b busy=%b want 1/1/0", ready4, ncs4, busy4);
      end
   endtask

   task automatic check_frame(input string name, input frame_res_t r, input logic [15:0] exp,
                              input int d);
      checks++; if (r.stream !== exp) begin failures++; $display("FAIL %s_stream got=%h want=%h", name, r.stream, exp); end
      checks++; if (r.rises != 16) begin failures++; $display("FAIL %s_rises got=%0d want=16", name, r.rises); end
      checks++; if (r.ncs_low != 33 * d) begin failures++; $display("FAIL %s_ncs_low got=%0d want=%0d", name, r.ncs_low, 33 * d); end
      checks++; if (r.done_at != 34 * d || r.done_cnt != 1) begin
         failures++; $display("FAIL %s_done at=%0d cnt=%0d want at=%0d cnt=1", name, r.done_at, r.done_cnt, 34 * d);
      end
      checks++; if (r.busy_cnt != 34 * d) begin failures++; $display("FAIL %s_busy got=%0d want=%0d", name, r.busy_cnt, 34 * d); end
      checks++; if (r.glitch != 0) begin failures++; $display("FAIL %s_timing violations=%0d want=0", name, r.glitch); end
   endtask

   task automatic test_write_frame();
      bit ok;
      frame_res_t r;
      sel1 = 1'b0;
      start_frame(1'b1, 7'h00, 8'hA5, ok);
      checks++; if (!ok) begin failures++; $display("FAIL wr_accept got=timeout want=accept"); return; end
      fork
         capture(4, r);
         begin #2; req_valid = 1'b0; end
      join
      check_frame("wr", r, 16'h80A5, 4);
   endtask

   task automatic test_back_to_back();
      bit ok;
      frame_res_t r1, r2;
      sel1 = 1'b0;
      start_frame(1'b1, 7'h01, 8'hFF, ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_accept got=timeout want=accept"); return; end
      fork
         capture(4, r1);
         begin #2; req_addr = 7'h02; req_data = 8'h0F; end
      join
      checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b want=1", obs_ready); end
      @(posedge clk);
      fork
         capture(4, r2);
         begin #2; req_valid = 1'b0; end
      join
      check_frame("b2b1", r1, 16'h81FF, 4);
      checks++; if (r1.ncs_high_tail != 5) begin failures++; $display("FAIL b2b_gap got=%0d want=5", r1.ncs_high_tail); end
      check_frame("b2b2", r2, 16'h820F, 4);
   endtask

   task automatic test_reset_midframe();
      bit ok;
      frame_res_t r;
      sel1 = 1'b0;
      start_frame(1'b1, 7'h33, 8'h55, ok);
      checks++; if (!ok) begin failures++; $display("FAIL mid_accept got=timeout want=accept"); return; end
      fork
         begin repeat (62) @(posedge clk); end
         begin #2; req_valid = 1'b0; end
      join
      #1;
      checks++; if (sclk4 !== 1'b1 || ncs4 !== 1'b0) begin
         failures++; $display("FAIL mid_active sclk=%b ncs=%b want 1/0", sclk4, ncs4);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (ncs4 !== 1'b1 || sclk4 !== 1'b0 || copi4 !== 1'b0 || busy4 !== 1'b0) begin
         failures++; $display("FAIL mid_async ncs=%b sclk=%b copi=%b busy=%b want 1/0/0/0", ncs4, sclk4, copi4, busy4);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (ready4 !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", ready4); end
      start_frame(1'b1, 7'h04, 8'h3C, ok);
      checks++; if (!ok) begin failures++; $display("FAIL mid_accept2 got=timeout want=accept"); return; end
      fork
         capture(4, r);
         begin #2; req_valid = 1'b0; end
      join
      check_frame("mid", r, 16'h843C, 4);
   endtask

   task automatic test_div1_read();
      bit ok;
      frame_res_t r;
      sel1 = 1'b1;
      start_frame(1'b0, 7'h7F, 8'h00, ok);
      checks++; if (!ok) begin failures++; $display("FAIL div1_accept got=timeout want=accept"); sel1 = 1'b0; return; end
      fork
         capture(1, r);
         begin #2; req_valid = 1'b0; end
      join
      check_frame("div1", r, 16'h7F00, 1);
      sel1 = 1'b0;
   endtask

   task automatic test_input_isolation();
      bit ok;
      frame_res_t r;
      sel1 = 1'b0;
      start_frame(1'b1, 7'h15, 8'h3C, ok);
      checks++; if (!ok) begin failures++; $display("FAIL iso_accept got=timeout want=accept"); return; end
      fork
         capture(4, r);
         begin
            #2;
            for (int i = 0; i < 120; i++) begin
               req_addr = 7'($urandom);
               req_data = 8'($urandom);
               req_rw   = 1'($urandom);
               @(negedge clk);
            end
            req_valid = 1'b0;
         end
      join
      check_frame("iso", r, 16'h953C, 4);
      @(posedge clk);
      #1;
      checks++; if (busy4 !== 1'b0 || ready4 !== 1'b1) begin
         failures++; $display("FAIL iso_idle busy=%b ready=%b want 0/1", busy4, ready4);
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_write_frame();
      test_back_to_back();
      test_reset_midframe();
      test_div1_read();
      test_input_isolation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
